booth_r4_seq_mult: RTL and testbench

- Parametrised sequential radix-4 Booth multiplier. Retires one Booth digit per clock.
- Supports signed and unsigned operands, selected per operation.
- Uses a valid/ready handshake on both the operand side and the result side.
- Sits in the datapath wherever a low-area WIDTH x WIDTH multiply is needed. Replaces the fixed 8-bit combinational partial-product path.

---
 rtl/booth_pkg.sv | 38 +++
 rtl/booth_pp_gen.sv | 38 +++
 rtl/booth_r4_seq_mult.sv | 166 ++++++++++++++++
 tb/tb_booth_r4_seq_mult.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the sequential radix-4 Booth multiplier:
//   - state_e      : controller states (IDLE / RUN / DONE)
//   - digit_e      : recoded Booth digit (0, +1, +2, -1, -2)
//   - booth_decode : maps the triplet {b[1], b[0], prev} to a digit
// ---------------------------------------------------------------------------
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      POS1 = 3'd1,
      POS2 = 3'd2,
      NEG1 = 3'd3,
      NEG2 = 3'd4
   } digit_e;

   // Radix-4 recoding of {b[i+1], b[i], b[i-1]}.
   function automatic digit_e booth_decode(input logic [2:0] trip);
      digit_e d;
      case (trip)
         3'b000, 3'b111: d = ZERO;
         3'b001, 3'b010: d = POS1;
         3'b011:         d = POS2;
         3'b100:         d = NEG2;
         3'b101, 3'b110: d = NEG1;
         default:        d = ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// ---------------------------------------------------------------------------
// booth_pp_gen
// Combinational partial-product selector for one radix-4 Booth digit.
// Ports:
//   mcand  in  PW  multiplicand, already aligned to the current digit
//   digit  in  3   Booth digit code (digit_e)
//   pp     out PW  0 / +M / -M / +2M / -2M, modulo 2^PW
// ---------------------------------------------------------------------------
module booth_pp_gen
   import booth_pkg::*;
#(
   parameter int PW = 16
) (
   input  logic [PW-1:0] mcand,
   input  digit_e        digit,
   output logic [PW-1:0] pp
);

   localparam logic [PW-1:0] ONE_C = {{(PW-1){1'b0}}, 1'b1};

   logic [PW-1:0] dbl_s;

   assign dbl_s = {mcand[PW-2:0], 1'b0};

   // Digit-driven select; negation is invert-plus-one so the adder stays plain.
   always_comb begin
      pp = {PW{1'b0}};
      case (digit)
         ZERO:    pp = {PW{1'b0}};
         POS1:    pp = mcand;
         POS2:    pp = dbl_s;
         NEG1:    pp = ~mcand + ONE_C;
         NEG2:    pp = ~dbl_s + ONE_C;
         default: pp = {PW{1'b0}};
      endcase
   end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// ---------------------------------------------------------------------------
// booth_r4_seq_mult
// Sequential radix-4 Booth multiplier, one digit per clock, signed or
// unsigned per operation, valid/ready on both sides.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE, 0 in reset)
//   is_signed           1: two's complement operands, 0: unsigned
//   a, b                multiplicand, multiplier (WIDTH bits)
//   out_valid/out_ready result handshake; product held while out_valid=1
//   product             2*WIDTH-bit exact product
//   busy                high while an operation is in RUN or DONE
// ---------------------------------------------------------------------------
module booth_r4_seq_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int N_DIGITS = WIDTH / 32'sd2 + 32'sd1;
   localparam int PW       = 2 * WIDTH;
   localparam int MW       = WIDTH + 32'sd2;
   localparam int CNT_W    = $clog2(N_DIGITS + 32'sd1);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(N_DIGITS - 32'sd1);
   localparam logic [CNT_W-1:0] INC_C  = {{(CNT_W-1){1'b0}}, 1'b1};

   generate
      if (((WIDTH % 32'sd2) != 32'sd0) || (WIDTH < 32'sd4)) begin : g_bad_width
         $error("booth_r4_seq_mult: WIDTH must be even and >= 4");
      end
   endgenerate

   state_e           state_r;
   state_e           state_s;
   logic [PW-1:0]    mcand_r;
   logic [MW-1:0]    mplier_r;
   logic             prev_r;
   logic [PW-1:0]    acc_r;
   logic [CNT_W-1:0] cnt_r;
   logic [PW-1:0]    product_r;
   logic             out_valid_r;
   logic             busy_r;

   digit_e           digit_s;
   logic [PW-1:0]    pp_s;
   logic [PW-1:0]    acc_sum_s;
   logic             last_s;
   logic             accept_s;
   logic [PW-1:0]    a_ext_s;
   logic [MW-1:0]    b_ext_s;

   // Multiplicand is widened to the full product width so left shifts never lose
   // bits; the multiplier gets two extra bits so the final digit sees the
   // sign (signed) or a zero top (unsigned, needed for the all-ones case).
   assign a_ext_s = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
   assign b_ext_s = {{2{is_signed & b[WIDTH-1]}}, b};

   assign digit_s   = booth_decode({mplier_r[1:0], prev_r});
   assign acc_sum_s = acc_r + pp_s;
   assign last_s    = (cnt_r == LAST_C);

   booth_pp_gen #(.PW(PW)) u_pp_gen (
      .mcand (mcand_r),
      .digit (digit_s),
      .pp    (pp_s)
   );

   assign in_ready  = (state_r == IDLE) & ~rst;
   assign out_valid = out_valid_r;
   assign busy      = busy_r;
   assign product   = product_r;

   // Next-state decode and operand acceptance.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_s  = RUN;
               accept_s = 1'b1;
            end else begin
               state_s  = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State register plus registered status outputs derived from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         out_valid_r <= (state_s == DONE);
         busy_r      <= (state_s != IDLE);
      end
   end

   // Datapath: operand capture in IDLE, one Booth digit retired per RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_r   <= {PW{1'b0}};
         mplier_r  <= {MW{1'b0}};
         prev_r    <= 1'b0;
         acc_r     <= {PW{1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         product_r <= {PW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  mcand_r  <= a_ext_s;
                  mplier_r <= b_ext_s;
                  prev_r   <= 1'b0;
                  acc_r    <= {PW{1'b0}};
                  cnt_r    <= {CNT_W{1'b0}};
               end
            end
            RUN: begin
               acc_r    <= acc_sum_s;
               mcand_r  <= {mcand_r[PW-3:0], 2'b00};
               mplier_r <= {{2{mplier_r[MW-1]}}, mplier_r[MW-1:2]};
               prev_r   <= mplier_r[1];
               cnt_r    <= cnt_r + INC_C;
               if (last_s) begin
                  product_r <= acc_sum_s;
               end
            end
            default: begin
               // DONE holds everything, product included.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// ---------------------------------------------------------------------------
// tb_booth_r4_seq_mult
// Exercises an 8-bit and a 16-bit instance: reset behaviour, signed/unsigned
// corners, backpressure with competing operands, asynchronous reset during
// RUN, then randomised operations against an integer-arithmetic model.
// ---------------------------------------------------------------------------
module tb_booth_r4_seq_mult;

   logic clk = 1'b0;

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   logic        rst8, iv8, ir8, sg8, ov8, ordy8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic        rst16, iv16, ir16, sg16, ov16, ordy16, busy16;
   logic [15:0] a16, b16;
   logic [31:0] p16;

   int n_checks = 0;
   int n_fail   = 0;

   booth_r4_seq_mult #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .is_signed(sg8),
      .a(a8), .b(b8), .out_valid(ov8), .out_ready(ordy8), .product(p8), .busy(busy8)
   );

   booth_r4_seq_mult #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16), .is_signed(sg16),
      .a(a16), .b(b16), .out_valid(ov16), .out_ready(ordy16), .product(p16), .busy(busy16)
   );

   task automatic check_eq(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic get_ir(input bit w16);
      return w16 ? ir16 : ir8;
   endfunction

   function automatic logic get_ov(input bit w16);
      return w16 ? ov16 : ov8;
   endfunction

   function automatic logic get_busy(input bit w16);
      return w16 ? busy16 : busy8;
   endfunction

   function automatic logic [31:0] get_p(input bit w16);
      return w16 ? p16 : {16'h0000, p8};
   endfunction

   // Reference: plain integer multiply of the operands interpreted per mode.
   function automatic logic [31:0] ref_mul(input bit w16, input bit s,
                                           input logic [15:0] x, input logic [15:0] y);
      longint xa, ya, pr;
      if (w16) begin
         xa = s ? longint'($signed(x)) : longint'(x);
         ya = s ? longint'($signed(y)) : longint'(y);
      end else begin
         xa = s ? longint'($signed(x[7:0])) : longint'(x[7:0]);
         ya = s ? longint'($signed(y[7:0])) : longint'(y[7:0]);
      end
      pr = xa * ya;
      return w16 ? pr[31:0] : {16'h0000, pr[15:0]};
   endfunction

   task automatic set_in(input bit w16, input logic v, input logic s,
                         input logic [15:0] x, input logic [15:0] y);
      if (w16) begin
         iv16 = v; sg16 = s; a16 = x; b16 = y;
      end else begin
         iv8 = v; sg8 = s; a8 = x[7:0]; b8 = y[7:0];
      end
   endtask

   task automatic set_ordy(input bit w16, input logic r);
      if (w16) ordy16 = r;
      else     ordy8  = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full operation: offer, accept, time the latency, stall, drain.
   task automatic run_op(input bit w16, input bit s, input logic [15:0] x, input logic [15:0] y,
                         input int stall, input bit junk, input logic [31:0] exp, input string tag);
      int t;
      int lat;
      int n_dig;
      n_dig = w16 ? 9 : 5;
      set_in(w16, 1'b1, s, x, y);
      t = 0;
      while (!get_ir(w16) && t < 50) begin
         tick();
         t++;
      end
      check_eq({tag, " ready"}, 48'(get_ir(w16)), 48'(1'b1));
      tick();
      if (junk) set_in(w16, 1'b1, ~s, 16'($urandom), 16'($urandom));
      else      set_in(w16, 1'b0, s, x, y);
      check_eq({tag, " busy"}, 48'({get_busy(w16), get_ir(w16), get_ov(w16)}), 48'(3'b100));
      lat = 0;
      while (!get_ov(w16) && lat < 40) begin
         tick();
         lat++;
      end
      check_eq({tag, " latency"}, 48'(lat), 48'(n_dig));
      check_eq({tag, " product"}, 48'(get_p(w16)), 48'(exp));
      for (int i = 0; i < stall; i++) begin
         tick();
         check_eq({tag, " hold"}, 48'({get_ov(w16), get_ir(w16), get_p(w16)}),
                  48'({1'b1, 1'b0, exp}));
      end
      set_ordy(w16, 1'b1);
      tick();
      set_ordy(w16, 1'b0);
      set_in(w16, 1'b0, s, x, y);
      check_eq({tag, " drain"}, 48'({get_ov(w16), get_busy(w16), get_ir(w16)}), 48'(3'b001));
   endtask

   // Hard stop in case anything wedges beyond the bounded waits.
   initial begin
      #5ms;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      rst8 = 1'b1;
      rst16 = 1'b1;
      ordy8 = 1'b0;
      ordy16 = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      set_in(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (3) @(posedge clk);
      #1;
      check_eq("in_ready in reset", 48'(ir8), 48'(1'b0));
      rst8 = 1'b0;
      rst16 = 1'b0;
      #1;
      check_eq("reset state 8", 48'({ir8, ov8, busy8, p8}), 48'({1'b1, 1'b0, 1'b0, 16'h0000}));
      check_eq("reset state 16", 48'({ir16, ov16, busy16, p16}), 48'({1'b1, 1'b0, 1'b0, 32'h0}));

      run_op(1'b0, 1'b1, 16'h0080, 16'h0080, 0, 1'b0, 32'h0000_4000, "s_min_sq");
      run_op(1'b0, 1'b1, 16'h00FF, 16'h007F, 0, 1'b0, 32'h0000_FF81, "s_m1x127");
      run_op(1'b0, 1'b0, 16'h00FF, 16'h007F, 0, 1'b0, 32'h0000_7E81, "u_255x127");
      run_op(1'b0, 1'b0, 16'h00FF, 16'h00FF, 0, 1'b0, 32'h0000_FE01, "u_max_sq");
      run_op(1'b0, 1'b1, 16'h007F, 16'h007F, 10, 1'b1, 32'h0000_3F01, "bp_hold");
      run_op(1'b0, 1'b0, 16'h0055, 16'h0033, 0, 1'b0, 32'h0000_10EF, "bp_next");
      run_op(1'b1, 1'b1, 16'h8000, 16'h8000, 0, 1'b0, 32'h4000_0000, "s16_min_sq");
      run_op(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 0, 1'b0, 32'hFFFE_0001, "u16_max_sq");

      // Abort after two digits with an asynchronous reset between edges.
      set_in(1'b0, 1'b1, 1'b0, 16'h0012, 16'h0034);
      tick();
      set_in(1'b0, 1'b0, 1'b0, 16'h0012, 16'h0034);
      tick();
      tick();
      #3;
      rst8 = 1'b1;
      #1;
      check_eq("async reset", 48'({ir8, ov8, busy8, p8}), 48'({1'b0, 1'b0, 1'b0, 16'h0000}));
      tick();
      rst8 = 1'b0;
      #1;
      check_eq("post reset ready", 48'({ir8, busy8}), 48'(2'b10));
      run_op(1'b0, 1'b0, 16'h0012, 16'h0034, 0, 1'b0, 32'h0000_03A8, "after_rst");

      for (int w = 0; w < 2; w++) begin
         for (int k = 0; k < (w == 0 ? 1500 : 800); k++) begin
            bit          s;
            logic [15:0] x, y;
            string       tg;
            s = bit'($urandom_range(0, 1));
            x = 16'($urandom);
            y = 16'($urandom);
            if ($urandom_range(0, 7) == 0) x = (w == 0) ? 16'h0080 : 16'h8000;
            if ($urandom_range(0, 7) == 0) y = (w == 0) ? 16'h00FF : 16'hFFFF;
            tg = (w == 0) ? "rnd8" : "rnd16";
            repeat ($urandom_range(0, 3)) tick();
            run_op(w[0], s, x, y, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                   ref_mul(w[0], s, x, y), tg);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
